fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Instruction-fetch controller for the pipelined MIPS core. It sits between the 32-bit PC register and the IF/ID boundary: it reads the current PC, drives the PC register's D/CE, runs the req/ack handshake to instruction memory and presents fetched instructions to decode. It handles back-pressure with a one-entry skid buffer, branch/jump redirects with stale-response dropping, and a wait-timeout error flag.

## Interface
- MAX_WAIT, 15, number of consecutive un-acked request cycles before fetch_err sets (4-bit counter, 1..15)
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- pc_q  in  32  current PC from PC register
- pc_d  out  32  next PC to PC register (combinational)
- pc_ce  out  1  PC register load enable (combinational)
- imem_req  out  1  instruction-memory request
- imem_addr  out  32  request address
- imem_ack  in  1  memory ack; rdata valid in the same cycle
- imem_rdata  in  32  instruction word
- redirect  in  1  branch/jump taken (from EX)
- redirect_pc  in  32  target PC
- stall  in  1  decode cannot accept; if_* must hold
- if_valid  out  1  IF/ID entry valid (registered)
- if_pc  out  32  PC of presented instruction (registered)
- if_pc4  out  32  if_pc + 4, modulo 2^32 (registered)
- if_instr  out  32  instruction word (registered)
- fetch_err  out  1  sticky timeout flag (registered)

## Operation
- States: IDLE, REQ, HOLD, DROP. Reset -> IDLE; all registered outputs 0, skid empty, wait counter 0.
- IDLE: outputs inactive; unconditionally -> REQ next cycle.
- REQ: imem_req=1, imem_addr=pc_q; req_addr register loads pc_q each REQ cycle.
  - ack, no redirect, capture allowed (if_valid=0 or stall=0): if_* <= {1, pc_q, pc_q+4, rdata}; pc_d=pc_q+4, pc_ce=1; stay REQ.
  - ack, no redirect, if_valid=1 and stall=1: skid <= {pc_q, pc_q+4, rdata}; pc_ce=1, pc_d=pc_q+4; -> HOLD.
  - no ack, no redirect: pc_ce=0; if capture allowed, if_valid <= 0.
  - redirect with ack: response discarded; -> REQ. Redirect without ack: -> DROP.
- HOLD: imem_req=0. stall=0: skid moves to if_*, if_valid <= 1, -> REQ. stall=1: hold everything.
- DROP: imem_req=1, imem_addr=req_addr (request kept stable until acked). On ack: data discarded, -> REQ. pc_ce=0 unless redirect.
- Redirect (any state except IDLE) has highest priority: pc_d=redirect_pc, pc_ce=1 that cycle; if_valid <= 0 and skid emptied next edge regardless of stall. HOLD + redirect -> REQ. DROP + redirect stays DROP (latest target wins).
- Wait counter: increments each cycle imem_req=1 and imem_ack=0, saturates at MAX_WAIT; clears on ack. Reaching MAX_WAIT sets fetch_err, cleared only by rst_n. Request is not abandoned on timeout.
- Handshake rule: once imem_req rises, imem_req and imem_addr stay stable until the ack cycle.

## Timing
- Zero-wait memory (ack same cycle as req): one instruction per cycle; if_* valid one edge after the ack cycle.
- pc_d/pc_ce are combinational; new PC visible on pc_q the cycle after the ack/redirect cycle, and requested that same cycle.
- Redirect-to-first-target-request latency: 1 cycle from REQ/HOLD; from DROP, 1 cycle after the stale ack.
- Stall released in HOLD: skid on if_* next edge, new request issued the following cycle.
- rst_n asserted mid-request: immediate return to IDLE, imem_req=0; any in-flight ack after reset is ignored.

## Test plan
- Reset then zero-wait memory returning 0x2000_0000+addr: if_pc sequence 0,4,8,..., if_valid=1 every cycle from cycle 2, if_instr matches.
- Ack delayed 3 cycles at pc=0x8: imem_addr=0x8 stable 4 cycles, if_valid=0 for 3 cycles, then if_pc=0x8, if_pc4=0xC.
- if_valid=1 with stall=1 for 4 cycles, ack for pc=0x10 arrives: HOLD entered, if_* unchanged, imem_req=0; stall drops -> if_pc=0x10 next edge.
- Redirect to 0x400 while request to 0x20 is waiting, ack 2 cycles later: stale word dropped, imem_addr=0x20 until ack, next request 0x400, first valid if_pc=0x400.
- Redirect coincident with ack, and redirect during HOLD: no stale if_valid, skid flushed, next if_pc = redirect_pc.
- Ack withheld 20 cycles, MAX_WAIT=15: fetch_err rises after 15 un-acked cycles, stays 1 after ack; clears only on rst_n.

Source files
------------

// File: rtl/fetch_ctrl_if.sv
// Instruction-memory request/acknowledge bus between the fetch controller
// (master) and instruction memory (slave). Read data is valid in the ack cycle.
interface fetch_ctrl_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: drives the PC register, runs the req/ack
// handshake to instruction memory and presents fetched words to decode.
// A one-entry skid buffer absorbs a response that arrives while decode is
// stalled, redirects drop any response still in flight for the old path,
// and a wait counter flags (sticky) a request left un-acked too long.
module fetch_ctrl #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [31:0]  pc_q,
    output logic [31:0]  pc_d,
    output logic         pc_ce,
    fetch_ctrl_if.master mem,
    input  logic         redirect,
    input  logic [31:0]  redirect_pc,
    input  logic         stall,
    output logic         if_valid,
    output logic [31:0]  if_pc,
    output logic [31:0]  if_pc4,
    output logic [31:0]  if_instr,
    output logic         fetch_err
);
    localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2,
        DROP = 2'd3
    } state_t;

    state_t      state_reg;
    logic [31:0] req_addr_reg;
    logic [3:0]  wait_cnt_reg;
    logic [3:0]  wait_cnt_next;
    logic        skid_valid_reg;
    logic [31:0] skid_pc_reg;
    logic [31:0] skid_pc4_reg;
    logic [31:0] skid_instr_reg;

    logic        requesting;
    logic        acked;
    logic        redirect_take;
    logic        capture_ok;
    logic [31:0] pc_plus4;

    // A request is outstanding in REQ and in DROP; DROP replays the address
    // latched while in REQ so the bus stays stable until the stale ack.
    assign requesting    = (state_reg == REQ) || (state_reg == DROP);
    assign acked         = requesting && mem.imem_ack;
    assign redirect_take = redirect && (state_reg != IDLE);
    assign capture_ok    = !if_valid || !stall;
    assign pc_plus4      = pc_q + 32'd4;

    assign mem.imem_req  = requesting;
    assign mem.imem_addr = (state_reg == DROP) ? req_addr_reg :
                           ((state_reg == REQ) ? pc_q : 32'd0);

    // Next-PC selection: redirect wins, otherwise advance on a live REQ ack.
    always_comb begin
        pc_d  = pc_q;
        pc_ce = 1'b0;
        if (redirect_take) begin
            pc_d  = redirect_pc;
            pc_ce = 1'b1;
        end else if (acked && (state_reg == REQ)) begin
            pc_d  = pc_plus4;
            pc_ce = 1'b1;
        end
    end

    // Count consecutive un-acked request cycles, saturating at the limit.
    always_comb begin
        wait_cnt_next = wait_cnt_reg;
        if (acked) begin
            wait_cnt_next = 4'd0;
        end else if (requesting && (wait_cnt_reg < WAIT_LIMIT)) begin
            wait_cnt_next = wait_cnt_reg + 4'd1;
        end
    end

    // Fetch FSM with registered IF/ID outputs, skid buffer and timeout flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            req_addr_reg   <= 32'd0;
            wait_cnt_reg   <= 4'd0;
            skid_valid_reg <= 1'b0;
            skid_pc_reg    <= 32'd0;
            skid_pc4_reg   <= 32'd0;
            skid_instr_reg <= 32'd0;
            if_valid       <= 1'b0;
            if_pc          <= 32'd0;
            if_pc4         <= 32'd0;
            if_instr       <= 32'd0;
            fetch_err      <= 1'b0;
        end else begin
            wait_cnt_reg <= wait_cnt_next;
            if (wait_cnt_next == WAIT_LIMIT) begin
                fetch_err <= 1'b1;
            end

            case (state_reg)
                IDLE: begin
                    state_reg <= REQ;
                end

                REQ: begin
                    req_addr_reg <= pc_q;
                    if (redirect) begin
                        // Wrong-path response: drop now if it is here,
                        // otherwise wait for it in DROP.
                        if_valid       <= 1'b0;
                        skid_valid_reg <= 1'b0;
                        state_reg      <= mem.imem_ack ? REQ : DROP;
                    end else if (mem.imem_ack) begin
                        if (capture_ok) begin
                            if_valid <= 1'b1;
                            if_pc    <= pc_q;
                            if_pc4   <= pc_plus4;
                            if_instr <= mem.imem_rdata;
                        end else begin
                            skid_valid_reg <= 1'b1;
                            skid_pc_reg    <= pc_q;
                            skid_pc4_reg   <= pc_plus4;
                            skid_instr_reg <= mem.imem_rdata;
                            state_reg      <= HOLD;
                        end
                    end else if (capture_ok) begin
                        if_valid <= 1'b0;
                    end
                end

                HOLD: begin
                    if (redirect) begin
                        if_valid       <= 1'b0;
                        skid_valid_reg <= 1'b0;
                        state_reg      <= REQ;
                    end else if (!stall) begin
                        if_valid       <= skid_valid_reg;
                        if_pc          <= skid_pc_reg;
                        if_pc4         <= skid_pc4_reg;
                        if_instr       <= skid_instr_reg;
                        skid_valid_reg <= 1'b0;
                        state_reg      <= REQ;
                    end
                end

                DROP: begin
                    if (redirect) begin
                        // Latest target wins; the old request is still owed an ack.
                        if_valid       <= 1'b0;
                        skid_valid_reg <= 1'b0;
                    end else if (mem.imem_ack) begin
                        state_reg <= REQ;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: a queue-based model of the IF/ID entry plus skid,
// a drop flag for wrong-path responses and an un-acked run counter give the
// expected outputs every cycle; directed sequences pin the model with literals,
// then randomized traffic exercises stalls, delays and redirects.
module tb_fetch_ctrl;
    localparam int MAX_WAIT = 15;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pc_q = 32'd0;
    logic [31:0] pc_d;
    logic        pc_ce;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        stall = 1'b0;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_pc4;
    logic [31:0] if_instr;
    logic        fetch_err;

    fetch_ctrl_if bus();

    fetch_ctrl #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pc_q       (pc_q),
        .pc_d       (pc_d),
        .pc_ce      (pc_ce),
        .mem        (bus),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .stall      (stall),
        .if_valid   (if_valid),
        .if_pc      (if_pc),
        .if_pc4     (if_pc4),
        .if_instr   (if_instr),
        .fetch_err  (fetch_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    // Model state: words held for decode (front = IF/ID entry), PC register,
    // pending wrong-path response, and the current un-acked run length.
    ent_t        q[$];
    bit          m_started;
    bit          m_drop;
    bit          m_err;
    logic [31:0] m_drop_addr;
    logic [31:0] m_pc;
    int          m_run;

    int          n_vec = 0;
    int          n_miss = 0;
    bit          data_from_addr = 1'b1;
    logic        last_req;
    logic [31:0] last_addr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_started = 1'b0;
        m_drop    = 1'b0;
        m_err     = 1'b0;
        m_run     = 0;
        m_pc      = 32'd0;
        m_drop_addr = 32'd0;
        q.delete();
        pc_q = 32'd0;
    endtask

    task automatic check_regs();
        chk("fetch_err", {31'd0, fetch_err}, {31'd0, m_err});
        chk("if_valid", {31'd0, if_valid}, (q.size() > 0) ? 32'd1 : 32'd0);
        if (q.size() > 0) begin
            chk("if_pc", if_pc, q[0].pc);
            chk("if_pc4", if_pc4, q[0].pc + 32'd4);
            chk("if_instr", if_instr, q[0].instr);
        end
    endtask

    // One clock cycle: check registered outputs, drive inputs, check the
    // combinational outputs, clock, then advance the model.
    task automatic step(input bit ack_i, input bit stall_i, input bit rd_i,
                        input logic [31:0] rd_pc_i, input logic [31:0] rdata_i);
        bit          e_req;
        bit          acked;
        bit          e_ce;
        logic [31:0] e_addr;
        logic [31:0] e_pcd;
        logic [31:0] rdata;
        ent_t        e;
        @(negedge clk);
        check_regs();
        e_req  = m_started && (m_drop || (q.size() < 2));
        e_addr = m_drop ? m_drop_addr : m_pc;
        rdata  = data_from_addr ? (32'h2000_0000 + e_addr) : rdata_i;
        acked  = e_req && ack_i;
        redirect       = rd_i;
        redirect_pc    = rd_pc_i;
        stall          = stall_i;
        bus.imem_ack   = ack_i;
        bus.imem_rdata = rdata;
        e_ce  = 1'b0;
        e_pcd = 32'd0;
        if (m_started && rd_i) begin
            e_ce  = 1'b1;
            e_pcd = rd_pc_i;
        end else if (acked && !m_drop) begin
            e_ce  = 1'b1;
            e_pcd = m_pc + 32'd4;
        end
        #1;
        chk("imem_req", {31'd0, bus.imem_req}, {31'd0, e_req});
        if (e_req) chk("imem_addr", bus.imem_addr, e_addr);
        chk("pc_ce", {31'd0, pc_ce}, {31'd0, e_ce});
        if (e_ce) chk("pc_d", pc_d, e_pcd);
        last_req  = bus.imem_req;
        last_addr = bus.imem_addr;
        if (acked)
            $display("ack addr=0x%08h data=0x%08h %s", e_addr, rdata,
                     (m_drop || rd_i) ? "dropped" : "kept");
        @(posedge clk);
        #1;
        if (e_req && !acked) m_run++;
        else if (acked) m_run = 0;
        if (m_run >= MAX_WAIT) m_err = 1'b1;
        if (!m_started) begin
            m_started = 1'b1;
        end else if (rd_i) begin
            q.delete();
            if (e_req && !acked) begin
                m_drop      = 1'b1;
                m_drop_addr = e_addr;
            end
            m_pc = rd_pc_i;
        end else begin
            if ((q.size() > 0) && !stall_i) void'(q.pop_front());
            if (acked) begin
                if (m_drop) begin
                    m_drop = 1'b0;
                end else begin
                    e.pc    = m_pc;
                    e.instr = rdata;
                    q.push_back(e);
                    m_pc = m_pc + 32'd4;
                end
            end
        end
        pc_q = m_pc;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        redirect = 1'b0;
        stall = 1'b0;
        bus.imem_ack = 1'b0;
        bus.imem_rdata = 32'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int ack_pct;
        int stall_pct;
        int rd_pct;
        logic [31:0] tgt;

        // Reset state
        do_reset();
        chk("rst if_valid", {31'd0, if_valid}, 32'd0);
        chk("rst if_pc", if_pc, 32'd0);
        chk("rst if_pc4", if_pc4, 32'd0);
        chk("rst if_instr", if_instr, 32'd0);
        chk("rst fetch_err", {31'd0, fetch_err}, 32'd0);
        chk("rst imem_req", {31'd0, bus.imem_req}, 32'd0);

        // Zero-wait memory: one instruction per cycle
        repeat (6) step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        chk("zw if_pc", if_pc, 32'h10);
        chk("zw if_instr", if_instr, 32'h2000_0010);
        chk("zw if_valid", {31'd0, if_valid}, 32'd1);

        // Ack delayed 3 cycles at 0x14
        repeat (3) begin
            step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
            chk("dly addr", last_addr, 32'h14);
            chk("dly if_valid", {31'd0, if_valid}, 32'd0);
        end
        step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        chk("dly addr ack", last_addr, 32'h14);
        chk("dly if_pc", if_pc, 32'h14);
        chk("dly if_pc4", if_pc4, 32'h18);

        // Stall with a valid entry, response lands in the skid
        repeat (3) step(1'b0, 1'b1, 1'b0, 32'd0, 32'd0);
        step(1'b1, 1'b1, 1'b0, 32'd0, 32'd0);
        step(1'b0, 1'b1, 1'b0, 32'd0, 32'd0);
        chk("hold imem_req", {31'd0, last_req}, 32'd0);
        chk("hold if_pc", if_pc, 32'h14);
        step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        chk("skid if_pc", if_pc, 32'h18);

        // Redirect while the 0x1C request waits; stale ack two cycles later
        step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        step(1'b0, 1'b0, 1'b1, 32'h400, 32'd0);
        chk("drop addr0", last_addr, 32'h1C);
        step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        chk("drop addr1", last_addr, 32'h1C);
        step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        chk("drop addr2", last_addr, 32'h1C);
        chk("drop if_valid", {31'd0, if_valid}, 32'd0);
        step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        chk("redir addr", last_addr, 32'h400);
        chk("redir if_pc", if_pc, 32'h400);

        // Redirect coincident with ack; target at top of memory (pc4 wraps)
        step(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'd0);
        chk("co if_valid", {31'd0, if_valid}, 32'd0);
        step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        chk("co addr", last_addr, 32'hFFFF_FFFC);
        chk("co if_pc", if_pc, 32'hFFFF_FFFC);
        chk("co if_pc4", if_pc4, 32'd0);

        // Redirect during HOLD flushes the skid
        step(1'b1, 1'b1, 1'b0, 32'd0, 32'd0);
        step(1'b0, 1'b1, 1'b1, 32'hC00, 32'd0);
        chk("hr if_valid", {31'd0, if_valid}, 32'd0);
        step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        chk("hr if_pc", if_pc, 32'hC00);

        // Timeout: 15 un-acked request cycles set the sticky flag
        repeat (14) step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        chk("to err14", {31'd0, fetch_err}, 32'd0);
        step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        chk("to err15", {31'd0, fetch_err}, 32'd1);
        repeat (5) step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        chk("to sticky", {31'd0, fetch_err}, 32'd1);

        // Asynchronous reset in the middle of a request; late ack ignored
        repeat (2) step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        rst_n = 1'b0;
        bus.imem_ack = 1'b1;
        #1;
        chk("arst imem_req", {31'd0, bus.imem_req}, 32'd0);
        chk("arst fetch_err", {31'd0, fetch_err}, 32'd0);
        chk("arst if_valid", {31'd0, if_valid}, 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        chk("arst first pc", if_pc, 32'd0);

        // Randomized traffic
        data_from_addr = 1'b0;
        ack_pct = 100;
        stall_pct = 0;
        rd_pct = 0;
        for (int i = 0; i < 3000; i++) begin
            if ((i % 250) == 0) begin
                ack_pct   = $urandom_range(25, 100);
                stall_pct = $urandom_range(0, 70);
                rd_pct    = $urandom_range(0, 12);
            end
            tgt = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ($urandom() & 32'hFFFF_FFFC);
            step($urandom_range(0, 99) < ack_pct,
                 $urandom_range(0, 99) < stall_pct,
                 $urandom_range(0, 99) < rd_pct,
                 tgt, $urandom());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
